// File: rtl/tdc_pkg.sv
// Shared types and constants for the TDC measurement controller.
// Fine codes come from a 64-tap delay line, so one coarse cycle spans TAPS fine units.
package tdc_pkg;

    localparam int TAPS   = 64;
    localparam int FINE_W = 6;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ARMED     = 3'd1,
        S_CAP_START = 3'd2,
        S_RUN       = 3'd3,
        S_CAP_STOP  = 3'd4,
        S_RESULT    = 3'd5
    } tdc_state_e;

    function automatic int interval_w(input int coarse_w);
        return coarse_w + FINE_W;
    endfunction

endpackage

// File: rtl/tdc_measure_ctrl_if.sv
// Control, delay-line and result handshake signals of the TDC measurement controller.
interface tdc_measure_ctrl_if
    import tdc_pkg::*;
#(
    parameter int COARSE_W = 16
);
    logic                       arm;
    logic                       start_edge;
    logic                       stop_edge;
    logic [FINE_W-1:0]          fine_count;
    logic                       sample;
    logic                       busy;
    logic                       res_valid;
    logic                       res_ready;
    logic [COARSE_W+FINE_W-1:0] res_interval;
    logic                       res_timeout;

    modport master (
        output arm, start_edge, stop_edge, fine_count, res_ready,
        input  sample, busy, res_valid, res_interval, res_timeout
    );

    modport slave (
        input  arm, start_edge, stop_edge, fine_count, res_ready,
        output sample, busy, res_valid, res_interval, res_timeout
    );
endinterface

// File: rtl/tdc_coarse_counter.sv
// Coarse cycle counter: synchronous clear, count enable, terminal flag at TIMEOUT_CYC.
module tdc_coarse_counter #(
    parameter int COARSE_W    = 16,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    input  logic                en,
    output logic [COARSE_W-1:0] count,
    output logic                tc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + COARSE_W'(1);
        end
    end

    assign tc = (count == COARSE_W'(TIMEOUT_CYC));

endmodule

// File: rtl/tdc_measure_ctrl.sv
// Start/stop interval measurement: coarse cycle count plus delay-line fine codes.
//   state     | meaning
//   IDLE      | waiting for arm, edges ignored
//   ARMED     | waiting for start_edge
//   CAP_START | delay line holds start fine code
//   RUN       | counting coarse cycles until stop_edge or timeout
//   CAP_STOP  | delay line holds stop fine code
//   RESULT    | result presented until res_ready
module tdc_measure_ctrl
    import tdc_pkg::*;
#(
    parameter int COARSE_W    = 16,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic               clk,
    input  logic               rst_n,
    tdc_measure_ctrl_if.slave  bus
);

    localparam int IW = interval_w(COARSE_W);

    tdc_state_e          state, state_d;
    logic                cnt_clr, cnt_en, cnt_tc;
    logic [COARSE_W-1:0] cnt;
    logic                pending;
    logic                take_stop;
    logic                timeout_hit;
    logic                sample;
    logic [FINE_W-1:0]   fine_start, fine_stop;
    logic [COARSE_W-1:0] coarse_stop;
    logic                timeout_q;
    logic [IW-1:0]       interval_calc;

    tdc_coarse_counter #(
        .COARSE_W    (COARSE_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_coarse (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .count (cnt),
        .tc    (cnt_tc)
    );

    // A stop latched during CAP_START is served in the first RUN cycle.
    assign take_stop   = (state == S_RUN) && (bus.stop_edge || pending);
    assign timeout_hit = (state == S_RUN) && !take_stop && cnt_tc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        sample  = 1'b0;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        unique case (state)
            S_IDLE: begin
                cnt_clr = 1'b1;
                if (bus.arm) state_d = S_ARMED;
            end
            S_ARMED: begin
                // Counter sits at 0 in the start cycle and reads k, k cycles later.
                if (bus.start_edge) begin
                    sample  = 1'b1;
                    cnt_en  = 1'b1;
                    state_d = S_CAP_START;
                end else begin
                    cnt_clr = 1'b1;
                end
            end
            S_CAP_START: begin
                cnt_en  = 1'b1;
                state_d = S_RUN;
            end
            S_RUN: begin
                cnt_en = !cnt_tc;
                if (take_stop) begin
                    sample  = 1'b1;
                    state_d = S_CAP_STOP;
                end else if (cnt_tc) begin
                    state_d = S_RESULT;
                end
            end
            S_CAP_STOP: begin
                state_d = S_RESULT;
            end
            S_RESULT: begin
                if (bus.res_ready) state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending     <= 1'b0;
            fine_start  <= '0;
            fine_stop   <= '0;
            coarse_stop <= '0;
            timeout_q   <= 1'b0;
        end else begin
            pending <= (state == S_CAP_START) && bus.stop_edge;
            if (state == S_CAP_START) fine_start <= bus.fine_count;
            if (state == S_CAP_STOP)  fine_stop  <= bus.fine_count;
            if (take_stop) begin
                coarse_stop <= pending ? (cnt - COARSE_W'(1)) : cnt;
            end
            if (state == S_ARMED) begin
                timeout_q <= 1'b0;
            end else if (timeout_hit) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign interval_calc = IW'(coarse_stop) * IW'(TAPS) + IW'(fine_start) - IW'(fine_stop);

    assign bus.sample       = sample;
    assign bus.busy         = (state != S_IDLE);
    assign bus.res_valid    = (state == S_RESULT);
    assign bus.res_timeout  = (state == S_RESULT) && timeout_q;
    assign bus.res_interval = ((state == S_RESULT) && !timeout_q) ? interval_calc : '0;

endmodule

// File: tb/tb_tdc_measure_ctrl.sv
// Directed bench for tdc_measure_ctrl with hand-computed intervals.
module tb_tdc_measure_ctrl;
    import tdc_pkg::*;

    localparam int COARSE_W    = 16;
    localparam int TIMEOUT_CYC = 100;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;
    int   sample_cnt;
    int   base;

    tdc_measure_ctrl_if #(.COARSE_W(COARSE_W)) bus ();

    tdc_measure_ctrl #(
        .COARSE_W    (COARSE_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial sample_cnt = 0;
    always @(posedge clk) begin
        if (bus.sample === 1'b1) sample_cnt <= sample_cnt + 1;
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.arm        = 1'b0;
        bus.start_edge = 1'b0;
        bus.stop_edge  = 1'b0;
        bus.fine_count = '0;
        bus.res_ready  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        tests = 0;
        fails = 0;
        clear_inputs();
        rst_n = 1'b0;
        step();
        #1;
        chk("rst_busy", bus.busy, 0);
        chk("rst_valid", bus.res_valid, 0);
        chk("rst_sample", bus.sample, 0);
        chk("rst_interval", bus.res_interval, 0);
        chk("rst_timeout", bus.res_timeout, 0);
        step();
        rst_n = 1'b1;

        // Basic measurement: 10*64 + 40 - 10
        step();
        base = sample_cnt;
        bus.arm = 1'b1; #1;
        chk("t1_idle_busy", bus.busy, 0);
        step();
        bus.arm = 1'b0; bus.start_edge = 1'b1; #1;
        chk("t1_start_sample", bus.sample, 1);
        chk("t1_armed_busy", bus.busy, 1);
        step();
        bus.start_edge = 1'b0; bus.fine_count = 6'd40; #1;
        chk("t1_capstart_sample", bus.sample, 0);
        repeat (8) step();
        step();
        bus.stop_edge = 1'b1; #1;
        chk("t1_stop_sample", bus.sample, 1);
        step();
        bus.stop_edge = 1'b0; bus.fine_count = 6'd10; #1;
        chk("t1_capstop_valid", bus.res_valid, 0);
        step(); #1;
        chk("t1_valid", bus.res_valid, 1);
        chk("t1_interval", bus.res_interval, 670);
        chk("t1_timeout", bus.res_timeout, 0);
        chk("t1_samples", sample_cnt - base, 2);
        bus.res_ready = 1'b1;
        step();
        bus.res_ready = 1'b0; #1;
        chk("t1_idle_after", bus.busy, 0);
        chk("t1_valid_after", bus.res_valid, 0);

        // Stop during CAP_START: coarse_stop=1, 64 + 0 - 63
        step();
        base = sample_cnt;
        bus.arm = 1'b1;
        step();
        bus.arm = 1'b0; bus.start_edge = 1'b1;
        step();
        bus.start_edge = 1'b0; bus.fine_count = 6'd0; bus.stop_edge = 1'b1; #1;
        chk("t2_capstart_sample", bus.sample, 0);
        step();
        bus.stop_edge = 1'b0; bus.fine_count = 6'd17; #1;
        chk("t2_pending_sample", bus.sample, 1);
        step();
        bus.fine_count = 6'd63; #1;
        chk("t2_capstop_valid", bus.res_valid, 0);
        step(); #1;
        chk("t2_valid", bus.res_valid, 1);
        chk("t2_interval", bus.res_interval, 1);
        chk("t2_samples", sample_cnt - base, 2);
        bus.res_ready = 1'b1;
        step();
        bus.res_ready = 1'b0;

        // Timeout after TIMEOUT_CYC coarse cycles
        step();
        base = sample_cnt;
        bus.arm = 1'b1;
        step();
        bus.arm = 1'b0; bus.start_edge = 1'b1;
        step();
        bus.start_edge = 1'b0; bus.fine_count = 6'd5;
        repeat (98) step();
        step(); #1;
        chk("t3_last_run_valid", bus.res_valid, 0);
        chk("t3_last_run_busy", bus.busy, 1);
        step(); #1;
        chk("t3_valid", bus.res_valid, 1);
        chk("t3_timeout", bus.res_timeout, 1);
        chk("t3_interval", bus.res_interval, 0);
        chk("t3_samples", sample_cnt - base, 1);
        bus.res_ready = 1'b1;
        step();
        bus.res_ready = 1'b0; #1;
        chk("t3_idle_after", bus.busy, 0);

        // Result held with res_ready low; 3*64 + 20 - 30
        step();
        bus.arm = 1'b1;
        step();
        bus.arm = 1'b0; bus.start_edge = 1'b1;
        step();
        bus.start_edge = 1'b0; bus.fine_count = 6'd20;
        step();
        step();
        bus.stop_edge = 1'b1;
        step();
        bus.stop_edge = 1'b0; bus.fine_count = 6'd30;
        step(); #1;
        chk("t4_valid", bus.res_valid, 1);
        chk("t4_interval", bus.res_interval, 182);
        base = sample_cnt;
        for (int i = 0; i < 20; i++) begin
            step();
            bus.start_edge = (i % 2 == 1);
            bus.stop_edge  = (i % 2 == 0);
            bus.arm        = (i % 3 == 0);
            #1;
            chk("t4_hold_valid", bus.res_valid, 1);
            chk("t4_hold_interval", bus.res_interval, 182);
            chk("t4_hold_sample", bus.sample, 0);
        end
        step();
        bus.start_edge = 1'b0; bus.stop_edge = 1'b0;
        bus.res_ready = 1'b1; bus.arm = 1'b1; #1;
        chk("t4_ack_valid", bus.res_valid, 1);
        step();
        bus.res_ready = 1'b0; bus.arm = 1'b0; #1;
        chk("t4_idle_after", bus.busy, 0);
        step(); #1;
        chk("t4_arm_ignored", bus.busy, 0);
        chk("t4_samples", sample_cnt - base, 0);

        // Stop alone in ARMED and coincident with start are ignored; 5*64 + 7 - 3
        step();
        bus.arm = 1'b1;
        step();
        bus.arm = 1'b0; bus.stop_edge = 1'b1; #1;
        chk("t5_armed_stop_sample", bus.sample, 0);
        step(); #1;
        chk("t5_still_armed", bus.busy, 1);
        bus.start_edge = 1'b1; #1;
        chk("t5_start_sample", bus.sample, 1);
        step();
        bus.start_edge = 1'b0; bus.stop_edge = 1'b0; bus.fine_count = 6'd7; #1;
        chk("t5_capstart_sample", bus.sample, 0);
        step(); #1;
        chk("t5_run_sample", bus.sample, 0);
        step();
        step();
        step();
        bus.stop_edge = 1'b1; #1;
        chk("t5_stop_sample", bus.sample, 1);
        step();
        bus.stop_edge = 1'b0; bus.fine_count = 6'd3;
        step(); #1;
        chk("t5_valid", bus.res_valid, 1);
        chk("t5_interval", bus.res_interval, 324);
        bus.res_ready = 1'b1;
        step();
        bus.res_ready = 1'b0;

        // Reset in RUN aborts; edges without arm do nothing afterwards
        step();
        bus.arm = 1'b1;
        step();
        bus.arm = 1'b0; bus.start_edge = 1'b1;
        step();
        bus.start_edge = 1'b0; bus.fine_count = 6'd11;
        repeat (3) step();
        #1;
        chk("t6_run_busy", bus.busy, 1);
        rst_n = 1'b0; #1;
        chk("t6_rst_busy", bus.busy, 0);
        chk("t6_rst_valid", bus.res_valid, 0);
        chk("t6_rst_sample", bus.sample, 0);
        chk("t6_rst_interval", bus.res_interval, 0);
        chk("t6_rst_timeout", bus.res_timeout, 0);
        step();
        rst_n = 1'b1;
        base = sample_cnt;
        for (int i = 0; i < 6; i++) begin
            step();
            bus.start_edge = (i % 2 == 0);
            bus.stop_edge  = (i % 2 == 1);
            #1;
            chk("t6_post_sample", bus.sample, 0);
        end
        step();
        bus.start_edge = 1'b0; bus.stop_edge = 1'b0; #1;
        chk("t6_post_busy", bus.busy, 0);
        chk("t6_post_valid", bus.res_valid, 0);
        chk("t6_post_samples", sample_cnt - base, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
